snoop_responder: RTL and testbench

Snoop-side responder for the split L2 cache. It accepts bus operations snooped from other processors and looks up the addressed set in the 8-way tag/MESI array. It returns the snoop result (NOHIT/HIT/HITM), applies the MESI downgrade or invalidation, and for a modified line it sequences the writeback before the state change. It is the responder to the snoop results the cache itself collects when it issues bus operations.

---
 rtl/snoop_responder_if.sv | 42 ++++
 rtl/snoop_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_snoop_responder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_responder_if.sv
// Snoop responder bus bundle.
// Groups the snooped-operation handshake, the tag/MESI array read/write port,
// the snoop result and the writeback handshake.
//   master : environment side (snooped bus, tag array, writeback engine)
//   slave  : snoop_responder
interface snoop_responder_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TAG_W   = 12,
    parameter int unsigned INDEX_W = 14,
    parameter int unsigned WAYS    = 8
);
    logic                    snp_valid;
    logic                    snp_ready;
    logic [1:0]              snp_op;
    logic [ADDR_W-1:0]       snp_addr;
    logic                    arr_rd_en;
    logic [INDEX_W-1:0]      arr_index;
    logic [WAYS*TAG_W-1:0]   arr_rd_tag;
    logic [WAYS*2-1:0]       arr_rd_mesi;
    logic                    arr_wr_en;
    logic [2:0]              arr_wr_way;
    logic [1:0]              arr_wr_mesi;
    logic                    res_valid;
    logic [1:0]              res;
    logic [2:0]              res_way;
    logic                    wb_req;
    logic [ADDR_W-1:0]       wb_addr;
    logic                    wb_ack;
    logic                    proto_err;

    modport master (
        output snp_valid, snp_op, snp_addr, arr_rd_tag, arr_rd_mesi, wb_ack,
        input  snp_ready, arr_rd_en, arr_index, arr_wr_en, arr_wr_way, arr_wr_mesi,
               res_valid, res, res_way, wb_req, wb_addr, proto_err
    );

    modport slave (
        input  snp_valid, snp_op, snp_addr, arr_rd_tag, arr_rd_mesi, wb_ack,
        output snp_ready, arr_rd_en, arr_index, arr_wr_en, arr_wr_way, arr_wr_mesi,
               res_valid, res, res_way, wb_req, wb_addr, proto_err
    );
endinterface

// File: rtl/snoop_responder.sv
// Snoop-side responder for the split L2 cache.
// Accepts a snooped bus operation, reads the addressed set of the 8-way
// tag/MESI array, returns NOHIT/HIT/HITM, applies the MESI downgrade or
// invalidation, and sequences the writeback of a modified line before its
// state change.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : snoop_responder_if.slave (snoop handshake, array port, result,
//          writeback handshake)
module snoop_responder #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned TAG_W    = 12,
    parameter int unsigned INDEX_W  = 14,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned WAYS     = 8
) (
    input logic              clk,
    input logic              rst,
    snoop_responder_if.slave bus
);
    localparam int unsigned LineW = ADDR_W - OFFSET_W;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpRwim  = 2'b10;
    localparam logic [1:0] OpInval = 2'b11;

    localparam logic [1:0] MesiI = 2'b00;
    localparam logic [1:0] MesiS = 2'b01;
    localparam logic [1:0] MesiE = 2'b10;
    localparam logic [1:0] MesiM = 2'b11;

    localparam logic [1:0] ResNohit = 2'b00;
    localparam logic [1:0] ResHit   = 2'b01;
    localparam logic [1:0] ResHitm  = 2'b10;

    typedef enum logic [2:0] {StIdle, StLookup, StRespond, StWb, StUpdate} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [LineW-1:0] line_q, line_d;     // latched line address {tag, index}
    logic [1:0]       res_q, res_d;
    logic [2:0]       way_q, way_d;
    logic             perr_q, perr_d;
    logic             wr_now_q, wr_now_d; // array write issued alongside the result
    logic             hitm_q, hitm_d;
    logic [1:0]       mesi_q, mesi_d;     // new MESI state for the hit way

    // Lookup of the set returned by the array.
    logic [WAYS-1:0]  match;
    logic             hit;
    logic             multi;
    logic [2:0]       hit_way;
    logic [1:0]       hit_mesi;

    always_comb begin
        match = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            match[w] = (bus.arr_rd_mesi[2*w +: 2] != MesiI) &&
                       (bus.arr_rd_tag[w*TAG_W +: TAG_W] == line_q[LineW-1 -: TAG_W]);
        end
        hit_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (match[w]) hit_way = 3'(w);
        end
        hit      = |match;
        multi    = (match & (match - WAYS'(1))) != '0;
        hit_mesi = bus.arr_rd_mesi[{hit_way, 1'b0} +: 2];
    end

    logic                snp_ready, arr_rd_en, arr_wr_en, res_valid, wb_req, proto_err;
    logic [INDEX_W-1:0]  arr_index;
    logic [2:0]          arr_wr_way, res_way;
    logic [1:0]          arr_wr_mesi, res;
    logic [ADDR_W-1:0]   wb_addr;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        line_d   = line_q;
        res_d    = res_q;
        way_d    = way_q;
        perr_d   = perr_q;
        wr_now_d = wr_now_q;
        hitm_d   = hitm_q;
        mesi_d   = mesi_q;

        snp_ready   = 1'b0;
        arr_rd_en   = 1'b0;
        arr_index   = line_q[INDEX_W-1:0];
        arr_wr_en   = 1'b0;
        arr_wr_way  = '0;
        arr_wr_mesi = '0;
        res_valid   = 1'b0;
        res         = '0;
        res_way     = '0;
        wb_req      = 1'b0;
        wb_addr     = '0;
        proto_err   = 1'b0;

        unique case (state_q)
            StIdle: begin
                snp_ready = 1'b1;
                arr_index = '0;
                if (bus.snp_valid) begin
                    arr_rd_en = 1'b1;
                    arr_index = bus.snp_addr[OFFSET_W +: INDEX_W];
                    op_d      = bus.snp_op;
                    line_d    = bus.snp_addr[ADDR_W-1:OFFSET_W];
                    state_d   = StLookup;
                end
            end
            StLookup: begin
                res_d    = ResNohit;
                perr_d   = multi;
                wr_now_d = 1'b0;
                hitm_d   = 1'b0;
                mesi_d   = MesiI;
                if (hit) begin
                    unique case (op_q)
                        OpRead: begin
                            res_d = ResHit;
                            if (hit_mesi == MesiE) begin
                                wr_now_d = 1'b1;
                                mesi_d   = MesiS;
                            end else if (hit_mesi == MesiM) begin
                                res_d  = ResHitm;
                                hitm_d = 1'b1;
                                mesi_d = MesiS;
                            end
                        end
                        OpWrite: perr_d = 1'b1;
                        OpRwim: begin
                            if (hit_mesi == MesiM) begin
                                res_d  = ResHitm;
                                hitm_d = 1'b1;
                            end else begin
                                res_d    = ResHit;
                                wr_now_d = 1'b1;
                            end
                        end
                        OpInval: begin
                            res_d = ResHit;
                            if (hit_mesi == MesiS) wr_now_d = 1'b1;
                            else                   perr_d   = 1'b1;
                        end
                    endcase
                end
                way_d   = (res_d == ResNohit) ? 3'd0 : hit_way;
                state_d = StRespond;
            end
            StRespond: begin
                res_valid = 1'b1;
                res       = res_q;
                res_way   = way_q;
                proto_err = perr_q;
                if (wr_now_q) begin
                    arr_wr_en   = 1'b1;
                    arr_wr_way  = way_q;
                    arr_wr_mesi = mesi_q;
                end
                state_d = hitm_q ? StWb : StIdle;
            end
            StWb: begin
                wb_req  = 1'b1;
                wb_addr = {line_q, OFFSET_W'(0)};
                if (bus.wb_ack) state_d = StUpdate;
            end
            StUpdate: begin
                arr_wr_en   = 1'b1;
                arr_wr_way  = way_q;
                arr_wr_mesi = mesi_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            line_q   <= '0;
            res_q    <= '0;
            way_q    <= '0;
            perr_q   <= 1'b0;
            wr_now_q <= 1'b0;
            hitm_q   <= 1'b0;
            mesi_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            line_q   <= line_d;
            res_q    <= res_d;
            way_q    <= way_d;
            perr_q   <= perr_d;
            wr_now_q <= wr_now_d;
            hitm_q   <= hitm_d;
            mesi_q   <= mesi_d;
        end
    end

    // Line offset is irrelevant to a snoop.
    logic unused_offset;
    assign unused_offset = ^bus.snp_addr[OFFSET_W-1:0];

    assign bus.snp_ready   = snp_ready;
    assign bus.arr_rd_en   = arr_rd_en;
    assign bus.arr_index   = arr_index;
    assign bus.arr_wr_en   = arr_wr_en;
    assign bus.arr_wr_way  = arr_wr_way;
    assign bus.arr_wr_mesi = arr_wr_mesi;
    assign bus.res_valid   = res_valid;
    assign bus.res         = res;
    assign bus.res_way     = res_way;
    assign bus.wb_req      = wb_req;
    assign bus.wb_addr     = wb_addr;
    assign bus.proto_err   = proto_err;
endmodule

// File: tb/tb_snoop_responder.sv
// Bench for snoop_responder: tag/MESI array model, table of directed cases,
// mid-operation reset sequence, and randomized snoops against a rule model.
module tb_snoop_responder;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RWIM  = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snoop_responder_if bus ();
    snoop_responder dut (.clk(clk), .rst(rst), .bus(bus.slave));

    logic [11:0] tag_mem  [16384][8];
    logic [1:0]  mesi_mem [16384][8];

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] res;
        logic [2:0] way;
        logic       perr;
        logic [1:0] wr_kind;   // 0 none, 1 with result, 2 after writeback
        logic [1:0] wr_mesi;
    } exp_t;

    typedef struct {
        string       name;
        logic [7:0]  tag_mask;
        logic [15:0] mesi;
        logic [1:0]  op;
        int          delay;
        exp_t        e;
    } vec_t;

    vec_t vecs [10];

    int o_rd, o_res_cnt, o_res_cyc, o_perr_stray, o_wr_cnt, o_wr_cyc, o_wb_cnt, o_wb_bad;
    int o_idx_bad, o_done;
    logic [1:0] o_res, o_wr_mesi;
    logic [2:0] o_res_way, o_wr_way;
    logic       o_perr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {3'b0, bus.arr_rd_en, bus.arr_index, bus.arr_wr_en, bus.arr_wr_way,
                bus.arr_wr_mesi, bus.res_valid, bus.res, bus.res_way, bus.wb_req,
                bus.wb_addr, bus.proto_err};
    endfunction

    task automatic load_bus(input int set);
        for (int w = 0; w < 8; w++) begin
            bus.arr_rd_tag[w*12 +: 12] = tag_mem[set][w];
            bus.arr_rd_mesi[2*w +: 2]  = mesi_mem[set][w];
        end
    endtask

    // Expected outcome straight from the per-op MESI rules.
    task automatic ref_model(input logic [1:0] op, input logic [31:0] addr, output exp_t e);
        int hits[$];
        int set;
        logic [1:0] st;
        set = int'(addr[19:6]);
        e = '0;
        for (int w = 0; w < 8; w++)
            if (mesi_mem[set][w] != 2'b00 && tag_mem[set][w] == addr[31:20]) hits.push_back(w);
        if (hits.size() == 0) return;
        st     = mesi_mem[set][hits[0]];
        e.perr = (hits.size() > 1);
        e.way  = 3'(hits[0]);
        e.res  = 2'd1;
        case (op)
            OP_READ: begin
                if (st == 2'b10) begin e.wr_kind = 2'd1; e.wr_mesi = 2'b01; end
                if (st == 2'b11) begin e.res = 2'd2; e.wr_kind = 2'd2; e.wr_mesi = 2'b01; end
            end
            OP_WRITE: begin e.res = 2'd0; e.way = 3'd0; e.perr = 1'b1; end
            OP_RWIM: begin
                e.res     = (st == 2'b11) ? 2'd2 : 2'd1;
                e.wr_kind = (st == 2'b11) ? 2'd2 : 2'd1;
                e.wr_mesi = 2'b00;
            end
            default: begin
                if (st == 2'b01) begin e.wr_kind = 2'd1; e.wr_mesi = 2'b00; end
                else e.perr = 1'b1;
            end
        endcase
    endtask

    // Drives one snoop from the current (IDLE) cycle until snp_ready returns,
    // acting as the tag array and recording every observable event.
    task automatic run_op(input logic [1:0] op, input logic [31:0] addr, input int delay,
                          input bit noise);
        int cyc;
        bit done;
        o_rd = 0; o_res_cnt = 0; o_res_cyc = -1; o_res = 0; o_res_way = 0; o_perr = 0;
        o_perr_stray = 0; o_wr_cnt = 0; o_wr_cyc = -1; o_wr_way = 0; o_wr_mesi = 0;
        o_wb_cnt = 0; o_wb_bad = 0; o_idx_bad = 0; o_done = -1;
        bus.snp_valid = 1'b1; bus.snp_op = op; bus.snp_addr = addr; bus.wb_ack = 1'b0;
        cyc = 0; done = 0;
        while (!done && cyc < 60) begin
            #1;
            if (cyc > 0 && bus.snp_ready) begin
                done = 1; o_done = cyc;
            end else begin
                if (cyc == 0 && !bus.snp_ready) o_idx_bad++;
                if (bus.arr_index != addr[19:6]) o_idx_bad++;
                if (bus.arr_rd_en) begin o_rd++; load_bus(int'(bus.arr_index)); end
                if (bus.res_valid) begin
                    o_res_cnt++; o_res_cyc = cyc; o_res = bus.res; o_res_way = bus.res_way;
                    o_perr = bus.proto_err;
                end else if (bus.proto_err) o_perr_stray++;
                if (bus.arr_wr_en) begin
                    o_wr_cnt++; o_wr_cyc = cyc; o_wr_way = bus.arr_wr_way;
                    o_wr_mesi = bus.arr_wr_mesi;
                    mesi_mem[int'(bus.arr_index)][int'(bus.arr_wr_way)] = bus.arr_wr_mesi;
                end
                if (bus.wb_req) begin
                    o_wb_cnt++;
                    if (bus.wb_addr != {addr[31:6], 6'b0}) o_wb_bad++;
                end
                @(negedge clk);
                cyc++;
                bus.snp_valid = 1'b0;
                if (noise) begin bus.snp_addr = $urandom; bus.snp_op = 2'($urandom); end
                bus.wb_ack = (cyc == 3 + delay) ||
                             (noise && (cyc == 1 || cyc == 2) && $urandom_range(0, 1) == 1);
            end
        end
        bus.wb_ack = 1'b0;
    endtask

    task automatic run_test(input string lbl, input logic [1:0] op, input logic [31:0] addr,
                            input int delay, input bit noise, input exp_t e);
        logic [15:0] pre, post, got;
        int set;
        bit hitm;
        set = int'(addr[19:6]);
        for (int w = 0; w < 8; w++) pre[2*w +: 2] = mesi_mem[set][w];
        run_op(op, addr, delay, noise);
        hitm = (e.res == 2'd2);
        chk({lbl, ".done_cycle"}, 64'(o_done), hitm ? 64'(5 + delay) : 64'd3);
        chk({lbl, ".rd_en_count"}, 64'(o_rd), 64'd1);
        chk({lbl, ".index_or_ready"}, 64'(o_idx_bad), 64'd0);
        chk({lbl, ".res_count"}, 64'(o_res_cnt), 64'd1);
        chk({lbl, ".res_cycle"}, 64'(o_res_cyc), 64'd2);
        chk({lbl, ".res"}, 64'(o_res), 64'(e.res));
        chk({lbl, ".res_way"}, 64'(o_res_way), 64'(e.way));
        chk({lbl, ".proto_err"}, 64'(o_perr), 64'(e.perr));
        chk({lbl, ".stray_proto_err"}, 64'(o_perr_stray), 64'd0);
        chk({lbl, ".wr_count"}, 64'(o_wr_cnt), (e.wr_kind != 0) ? 64'd1 : 64'd0);
        if (e.wr_kind != 0) begin
            chk({lbl, ".wr_cycle"}, 64'(o_wr_cyc), (e.wr_kind == 1) ? 64'd2 : 64'(4 + delay));
            chk({lbl, ".wr_way"}, 64'(o_wr_way), 64'(e.way));
            chk({lbl, ".wr_mesi"}, 64'(o_wr_mesi), 64'(e.wr_mesi));
        end
        chk({lbl, ".wb_cycles"}, 64'(o_wb_cnt), hitm ? 64'(delay + 1) : 64'd0);
        chk({lbl, ".wb_addr"}, 64'(o_wb_bad), 64'd0);
        post = pre;
        if (e.wr_kind != 0) post[2*e.way +: 2] = e.wr_mesi;
        for (int w = 0; w < 8; w++) got[2*w +: 2] = mesi_mem[set][w];
        chk({lbl, ".set_mesi"}, 64'(got), 64'(post));
    endtask

    task automatic set_vec(input int i, input string n, input logic [7:0] m, input logic [15:0] s,
                           input logic [1:0] op, input int d, input logic [1:0] r,
                           input logic [2:0] w, input logic p, input logic [1:0] k,
                           input logic [1:0] nm);
        vecs[i].name = n; vecs[i].tag_mask = m; vecs[i].mesi = s; vecs[i].op = op;
        vecs[i].delay = d;
        vecs[i].e = '{res: r, way: w, perr: p, wr_kind: k, wr_mesi: nm};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] pool [3];
        exp_t e;
        logic [31:0] a;
        pool[0] = 12'h111; pool[1] = 12'h222; pool[2] = 12'h333;

        bus.snp_valid = 1'b0; bus.snp_op = '0; bus.snp_addr = '0;
        bus.arr_rd_tag = '0; bus.arr_rd_mesi = '0; bus.wb_ack = 1'b0;
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 8; w++) begin tag_mem[s][w] = 12'h0; mesi_mem[s][w] = 2'b00; end

        //                 name         mask   mesi      op       dly res way perr kind mesi
        set_vec(0, "all_inv",      8'h00, 16'h0000, OP_READ,  0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
        set_vec(1, "read_e",       8'h04, 16'h0020, OP_READ,  0, 2'd1, 3'd2, 1'b0, 2'd1, 2'b01);
        set_vec(2, "rwim_m",       8'h80, 16'hC000, OP_RWIM,  3, 2'd2, 3'd7, 1'b0, 2'd2, 2'b00);
        set_vec(3, "inv_dual_s",   8'h28, 16'h0440, OP_INV,   0, 2'd1, 3'd3, 1'b1, 2'd1, 2'b00);
        set_vec(4, "write_s",      8'h02, 16'h0004, OP_WRITE, 0, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0);
        set_vec(5, "inv_m",        8'h10, 16'h0300, OP_INV,   0, 2'd1, 3'd4, 1'b1, 2'd0, 2'd0);
        set_vec(6, "read_s",       8'h01, 16'h0001, OP_READ,  0, 2'd1, 3'd0, 1'b0, 2'd0, 2'd0);
        set_vec(7, "read_m_ack0",  8'h40, 16'h3000, OP_READ,  0, 2'd2, 3'd6, 1'b0, 2'd2, 2'b01);
        set_vec(8, "read_skip_i",  8'h42, 16'h2000, OP_READ,  0, 2'd1, 3'd6, 1'b0, 2'd1, 2'b01);
        set_vec(9, "rwim_miss",    8'h00, 16'h0080, OP_RWIM,  0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);

        // Reset state.
        @(negedge clk); #1;
        chk("reset.snp_ready", 64'(bus.snp_ready), 64'd1);
        chk("reset.outputs", outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_release.outputs", outs(), 64'd0);

        for (int i = 0; i < 10; i++) begin
            for (int w = 0; w < 8; w++) begin
                tag_mem[0][w]  = vecs[i].tag_mask[w] ? 12'h111 : 12'h222;
                mesi_mem[0][w] = vecs[i].mesi[2*w +: 2];
            end
            run_test(vecs[i].name, vecs[i].op, 32'h1110_0000, vecs[i].delay, 1'b0, vecs[i].e);
        end

        // Reset while a HITM writeback is pending.
        tag_mem[5][1] = 12'h111; mesi_mem[5][1] = 2'b11;
        bus.snp_valid = 1'b1; bus.snp_op = OP_READ; bus.snp_addr = {12'h111, 14'd5, 6'd0};
        #1 load_bus(5);
        @(negedge clk); bus.snp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("mid_rst.wb_req_before", 64'(bus.wb_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst.outputs", outs(), 64'd0);
        chk("mid_rst.snp_ready", 64'(bus.snp_ready), 64'd1);
        bus.wb_ack = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("mid_rst.hold_wr", 64'(bus.arr_wr_en), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0; bus.wb_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mid_rst.after_release", {61'd0, bus.arr_wr_en, bus.wb_req, bus.snp_ready},
                   64'd1);
            @(negedge clk);
        end
        tag_mem[5][2] = 12'h111; mesi_mem[5][2] = 2'b01;
        tag_mem[5][1] = 12'h222;
        ref_model(OP_READ, {12'h111, 14'd5, 6'd0}, e);
        run_test("after_rst_read", OP_READ, {12'h111, 14'd5, 6'd0}, 0, 1'b0, e);

        // Randomized snoops over four sets.
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 8; w++) begin
                tag_mem[s][w]  = pool[$urandom_range(0, 2)];
                mesi_mem[s][w] = ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'b00;
            end
        for (int n = 0; n < 300; n++) begin
            int s, w;
            logic [1:0] op;
            s = $urandom_range(0, 3); w = $urandom_range(0, 7);
            tag_mem[s][w]  = pool[$urandom_range(0, 2)];
            mesi_mem[s][w] = ($urandom_range(0, 1) == 1) ? 2'($urandom) : 2'b00;
            a  = {pool[$urandom_range(0, 2)], 14'($urandom_range(0, 3)), 6'($urandom)};
            op = 2'($urandom);
            ref_model(op, a, e);
            run_test($sformatf("rand%0d", n), op, a, $urandom_range(0, 4), 1'b1, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
